gray_conv_pipe: RTL and testbench

Parametrised, pipelined Gray/binary code converter with a valid/ready stream interface. Each accepted word carries its own direction: Gray→binary or binary→Gray. In Gray→binary mode the block also checks that successive Gray words are adjacent, meaning they differ in at most one bit. Sits between encoder/counter front-ends and binary datapath logic, and supersedes fixed 4-bit combinational decoding.

---
 rtl/gray_conv_pipe.sv | 113 +++++++++++
 tb/tb_gray_conv_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_pipe.sv
// Two-stage Gray<->binary stream converter with per-word direction and Gray adjacency checking.
// Latency 2 edges; in_ready drops only when both stages are full and out_ready is low.
module gray_conv_pipe #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic             clr_hist,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_err,
  output logic [ERRW-1:0]  err_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic             mode;
    logic             err;
  } stage_t;

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERRW-1:0]  CNT_MAX = {ERRW{1'b1}};

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  stage_t           s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic             s2_load;
  logic             in_fire;
  logic [WIDTH-1:0] hist_data;
  logic             hist_vld;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;
  logic             in_err;

  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = rst_n && (!s1_valid || s2_load);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Clearing the lowest set bit leaves something only when two or more bits differ.
  assign diff      = in_data ^ hist_data;
  assign multi_bit = |(diff & (diff - ONE));
  assign in_err    = !in_mode && hist_vld && !clr_hist && multi_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_q     <= '{dat: in_data, mode: in_mode, err: in_err};
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_mode <= 1'b0;
      out_err  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s1_q.mode ? b2g(s1_q.dat) : g2b(s1_q.dat);
        out_mode <= s1_q.mode;
        out_err  <= s1_q.err;
      end
    end
  end

  // An accepted G2B word always becomes the history, even when clr_hist arrives with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_data <= '0;
      hist_vld  <= 1'b0;
    end else if (in_fire && !in_mode) begin
      hist_data <= in_data;
      hist_vld  <= 1'b1;
    end else if (clr_hist) begin
      hist_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (in_fire && in_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Directed bench for gray_conv_pipe: vector table streamed back-to-back, then stall and mid-stream reset sequences.
module tb_gray_conv_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_mode = 1'b0;
  logic       clr_hist = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] in_data = 4'b0;
  logic       in_ready, out_valid, out_mode, out_err;
  logic [3:0] out_data;
  logic [7:0] err_cnt;
  logic       in_ready2, out_valid2, out_mode2, out_err2;
  logic [3:0] out_data2;
  logic [1:0] err_cnt2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] din;
    logic       mode;
    logic       clr;
    logic [3:0] exp_dat;
    logic       exp_err;
    int         exp_cnt;
  } vec_t;

  vec_t       vt[$];
  logic [3:0] bp_in[4];
  logic [3:0] bp_exp[4];
  int         w;
  int         rcv;
  int         sat;

  gray_conv_pipe #(.WIDTH(4), .ERRW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .clr_hist(clr_hist),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .out_err(out_err), .err_cnt(err_cnt)
  );

  gray_conv_pipe #(.WIDTH(4), .ERRW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_mode(in_mode), .clr_hist(clr_hist),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_mode(out_mode2), .out_err(out_err2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic [3:0] din, input logic mode, input logic clr,
                      input logic [3:0] dat, input logic err, input int cnt);
    vec_t v;
    v.din = din; v.mode = mode; v.clr = clr;
    v.exp_dat = dat; v.exp_err = err; v.exp_cnt = cnt;
    vt.push_back(v);
  endtask

  task automatic check_out(input int i);
    chk($sformatf("vec%0d valid", i), out_valid, 1'b1);
    chk($sformatf("vec%0d data", i), out_data, vt[i].exp_dat);
    chk($sformatf("vec%0d mode", i), out_mode, vt[i].mode);
    chk($sformatf("vec%0d err", i), out_err, vt[i].exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    addv(4'b1000, 1'b0, 1'b0, 4'b1111, 1'b0, 0);
    addv(4'b1010, 1'b1, 1'b0, 4'b1111, 1'b0, 0);
    // Full Gray cycle; the 1000 -> 0000 wrap closes it.
    addv(4'b0000, 1'b0, 1'b0, 4'd0,  1'b0, 0);
    addv(4'b0001, 1'b0, 1'b0, 4'd1,  1'b0, 0);
    addv(4'b0011, 1'b0, 1'b0, 4'd2,  1'b0, 0);
    addv(4'b0010, 1'b0, 1'b0, 4'd3,  1'b0, 0);
    addv(4'b0110, 1'b0, 1'b0, 4'd4,  1'b0, 0);
    addv(4'b0111, 1'b0, 1'b0, 4'd5,  1'b0, 0);
    addv(4'b0101, 1'b0, 1'b0, 4'd6,  1'b0, 0);
    addv(4'b0100, 1'b0, 1'b0, 4'd7,  1'b0, 0);
    addv(4'b1100, 1'b0, 1'b0, 4'd8,  1'b0, 0);
    addv(4'b1101, 1'b0, 1'b0, 4'd9,  1'b0, 0);
    addv(4'b1111, 1'b0, 1'b0, 4'd10, 1'b0, 0);
    addv(4'b1110, 1'b0, 1'b0, 4'd11, 1'b0, 0);
    addv(4'b1010, 1'b0, 1'b0, 4'd12, 1'b0, 0);
    addv(4'b1011, 1'b0, 1'b0, 4'd13, 1'b0, 0);
    addv(4'b1001, 1'b0, 1'b0, 4'd14, 1'b0, 0);
    addv(4'b1000, 1'b0, 1'b0, 4'd15, 1'b0, 0);
    addv(4'b0000, 1'b0, 1'b0, 4'd0,  1'b0, 0);
    // Repeat, errors, clear-with-word, then more errors to saturate the 2-bit counter.
    addv(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 0);
    addv(4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 1);
    addv(4'b1111, 1'b0, 1'b1, 4'b1010, 1'b0, 1);
    addv(4'b1110, 1'b0, 1'b0, 4'b1011, 1'b0, 1);
    addv(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2);
    addv(4'b0111, 1'b0, 1'b0, 4'b0101, 1'b1, 3);
    addv(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 4);
    addv(4'b1111, 1'b0, 1'b0, 4'b1010, 1'b1, 5);
    addv(4'b1111, 1'b0, 1'b0, 4'b1010, 1'b0, 5);

    bp_in[0] = 4'b0001; bp_exp[0] = 4'b0001;
    bp_in[1] = 4'b0010; bp_exp[1] = 4'b0011;
    bp_in[2] = 4'b0011; bp_exp[2] = 4'b0010;
    bp_in[3] = 4'b0100; bp_exp[3] = 4'b0110;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_data", out_data, 4'b0);
    chk("rst err_cnt", err_cnt, 8'd0);
    rst_n = 1'b1;
    tick();
    chk("post-rst in_ready", in_ready, 1'b1);

    // Table, streamed one word per cycle with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      in_valid = 1'b1;
      in_data  = vt[i].din;
      in_mode  = vt[i].mode;
      clr_hist = vt[i].clr;
      tick();
      sat = (vt[i].exp_cnt > 3) ? 3 : vt[i].exp_cnt;
      chk($sformatf("vec%0d err_cnt", i), err_cnt, vt[i].exp_cnt);
      chk($sformatf("vec%0d err_cnt sat", i), err_cnt2, sat);
      if (i == 0) chk("first word latency", out_valid, 1'b0);
      else check_out(i - 1);
    end
    in_valid = 1'b0;
    clr_hist = 1'b0;
    tick();
    check_out(vt.size() - 1);
    tick();
    chk("table drained", out_valid, 1'b0);

    // Backpressure: 6 stalled cycles while 4 words are offered
    out_ready = 1'b0;
    in_mode   = 1'b1;
    w = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (w < 4);
      in_data  = bp_in[(w < 4) ? w : 3];
      @(negedge clk);
      if (c >= 2) chk($sformatf("stall hold %0d", c), {out_valid, out_data}, {1'b1, bp_exp[0]});
      if (in_valid && in_ready) w++;
      @(posedge clk);
      #1;
    end
    chk("stall accepted", w, 2);
    chk("stall in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("in_ready follows out_ready", in_ready, 1'b1);
    rcv = 0;
    for (int c = 0; c < 20 && (rcv < 4 || w < 4); c++) begin
      in_valid = (w < 4);
      in_data  = bp_in[(w < 4) ? w : 3];
      @(negedge clk);
      if (in_valid && in_ready) w++;
      if (out_valid) begin
        if (rcv < 4) chk($sformatf("bp out %0d", rcv), out_data, bp_exp[rcv]);
        else chk("bp duplicate", out_valid, 1'b0);
        rcv++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("bp count", rcv, 4);
    chk("bp drained", out_valid, 1'b0);

    // Reset with both stages full
    out_ready = 1'b0;
    in_mode   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'b0101;
    tick();
    in_data   = 4'b1010;
    tick();
    in_valid  = 1'b0;
    chk("pre-rst full in_ready", in_ready, 1'b0);
    chk("pre-rst out_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", out_valid, 1'b0);
    chk("mid-rst out_data", out_data, 4'b0);
    chk("mid-rst out_mode", out_mode, 1'b0);
    chk("mid-rst out_err", out_err, 1'b0);
    chk("mid-rst in_ready", in_ready, 1'b0);
    chk("mid-rst err_cnt", err_cnt, 8'd0);
    chk("mid-rst err_cnt sat", err_cnt2, 2'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("no stale output", out_valid, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'b0011;
    tick();
    in_valid = 1'b0;
    chk("post-rst word err_cnt", err_cnt, 8'd0);
    tick();
    chk("post-rst word valid", out_valid, 1'b1);
    chk("post-rst word data", out_data, 4'b0010);
    chk("post-rst word unchecked", out_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
